// File: rtl/ber_ctrl_pkg.sv
// Shared types and constants for the BER measurement controller.
// The alignment length is derived from the checker's PRBS length.
package ber_ctrl_pkg;

    localparam int SEQ_LEN_DEF = 511;
    localparam int REG_LEN_DEF = 32;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CLEAR   = 3'd1,
        ALIGN   = 3'd2,
        MEASURE = 3'd3,
        DONE    = 3'd4
    } state_t;

    function automatic int align_len(input int seq_len);
        return seq_len * (seq_len + 1) + 1;
    endfunction

    function automatic int align_width(input int seq_len);
        return $clog2(align_len(seq_len) + 1);
    endfunction

    localparam int ALIGN_LEN_DEF = align_len(SEQ_LEN_DEF);
    localparam int ALIGN_W_DEF   = align_width(SEQ_LEN_DEF);

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// count presents the running total including this cycle's increment.
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc_en,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;

    always_comb begin
        count = count_q;
        if (clr) begin
            count = '0;
        end else if (inc_en && inc && (count_q != '1)) begin
            count = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count;
        end
    end

endmodule

// File: rtl/ber_ctrl.sv
// Sequencer for one BER measurement window: clear, PRBS alignment, counting, commit.
//   state   | meaning
//   IDLE    | waiting for start; results held
//   CLEAR   | one cycle of ber_clr to the checker
//   ALIGN   | let the checker lock; ALIGN_LEN ticks discarded
//   MEASURE | count bits and errors until win_len bits seen
//   DONE    | results committed, done pulse
import ber_ctrl_pkg::*;

module ber_ctrl #(
    parameter int SEQ_LEN = SEQ_LEN_DEF,
    parameter int REG_LEN = REG_LEN_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [REG_LEN-1:0] win_len,
    input  logic               sample_tick,
    input  logic               err_in,
    output logic               ber_enable,
    output logic               ber_clr,
    output logic               busy,
    output logic               done,
    output logic               aborted,
    output logic               cfg_err,
    output logic [REG_LEN-1:0] res_bits,
    output logic [REG_LEN-1:0] res_errs
);

    localparam int ALIGN_LEN = align_len(SEQ_LEN);
    localparam int ALIGN_W   = align_width(SEQ_LEN);

    state_t               state;
    logic [REG_LEN-1:0]   win_q;
    logic [REG_LEN-1:0]   bit_cnt;
    logic [REG_LEN-1:0]   bit_nxt;
    logic [REG_LEN-1:0]   err_run;
    logic [ALIGN_W-1:0]   align_cnt;
    logic                 accept;
    logic                 err_inc_en;

    assign accept     = (state == IDLE) && start && !abort && (win_len != '0);
    assign err_inc_en = (state == MEASURE) && sample_tick && !abort;
    assign bit_nxt    = bit_cnt + 1'b1;
    assign ber_enable = sample_tick && ((state == ALIGN) || (state == MEASURE));
    assign busy       = (state != IDLE);

    sat_counter #(
        .WIDTH (REG_LEN)
    ) u_err_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr    (accept),
        .inc_en (err_inc_en),
        .inc    (err_in),
        .count  (err_run)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            win_q     <= '0;
            bit_cnt   <= '0;
            align_cnt <= '0;
            res_bits  <= '0;
            res_errs  <= '0;
            done      <= 1'b0;
            aborted   <= 1'b0;
            cfg_err   <= 1'b0;
            ber_clr   <= 1'b0;
        end else begin
            done    <= 1'b0;
            aborted <= 1'b0;
            cfg_err <= 1'b0;
            ber_clr <= 1'b0;
            case (state)
                IDLE: begin
                    // abort in IDLE has nothing to cancel but still swallows a start
                    if (start && !abort) begin
                        if (win_len == '0) begin
                            cfg_err <= 1'b1;
                        end else begin
                            win_q     <= win_len;
                            bit_cnt   <= '0;
                            align_cnt <= '0;
                            ber_clr   <= 1'b1;
                            state     <= CLEAR;
                        end
                    end
                end
                CLEAR: begin
                    if (abort) begin
                        aborted <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        state <= ALIGN;
                    end
                end
                ALIGN: begin
                    if (abort) begin
                        aborted <= 1'b1;
                        state   <= IDLE;
                    end else if (sample_tick) begin
                        align_cnt <= align_cnt + 1'b1;
                        if (align_cnt == ALIGN_W'(ALIGN_LEN - 1)) begin
                            state <= MEASURE;
                        end
                    end
                end
                MEASURE: begin
                    if (abort) begin
                        aborted <= 1'b1;
                        state   <= IDLE;
                    end else if (sample_tick) begin
                        bit_cnt <= bit_nxt;
                        if (bit_nxt == win_q) begin
                            res_bits <= bit_nxt;
                            res_errs <= err_run;
                            done     <= 1'b1;
                            state    <= DONE;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ber_ctrl.sv
// Bench for ber_ctrl: directed table of runs plus random runs checked against a tick-counting model.
// Two instances with SEQ_LEN=7: a 32-bit one and a 4-bit one for the narrow-counter cases.
module tb_ber_ctrl;

    localparam int ALEN = 57;
    localparam int MAXE = 1024;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        start_a, abort_a, tick_a, err_a;
    logic [31:0] win_a;
    logic        en_a, clr_a, busy_a, done_a, abd_a, cfg_a;
    logic [31:0] bits_a, errs_a;

    logic        start_b, abort_b, tick_b, err_b;
    logic [3:0]  win_b;
    logic        en_b, clr_b, busy_b, done_b, abd_b, cfg_b;
    logic [3:0]  bits_b, errs_b;

    ber_ctrl #(.SEQ_LEN(7), .REG_LEN(32)) dut_a (
        .clk(clk), .rst(rst_n), .start(start_a), .abort(abort_a), .win_len(win_a),
        .sample_tick(tick_a), .err_in(err_a), .ber_enable(en_a), .ber_clr(clr_a),
        .busy(busy_a), .done(done_a), .aborted(abd_a), .cfg_err(cfg_a),
        .res_bits(bits_a), .res_errs(errs_a)
    );

    ber_ctrl #(.SEQ_LEN(7), .REG_LEN(4)) dut_b (
        .clk(clk), .rst(rst_n), .start(start_b), .abort(abort_b), .win_len(win_b),
        .sample_tick(tick_b), .err_in(err_b), .ber_enable(en_b), .ber_clr(clr_b),
        .busy(busy_b), .done(done_b), .aborted(abd_b), .cfg_err(cfg_b),
        .res_bits(bits_b), .res_errs(errs_b)
    );

    bit          use_b;
    logic        c_en, c_clr, c_busy, c_done, c_abd, c_cfg;
    logic [31:0] c_bits, c_errs;

    always_comb begin
        c_en   = use_b ? en_b   : en_a;
        c_clr  = use_b ? clr_b  : clr_a;
        c_busy = use_b ? busy_b : busy_a;
        c_done = use_b ? done_b : done_a;
        c_abd  = use_b ? abd_b  : abd_a;
        c_cfg  = use_b ? cfg_b  : cfg_a;
        c_bits = use_b ? {28'd0, bits_b} : bits_a;
        c_errs = use_b ? {28'd0, errs_b} : errs_a;
    end

    int vec_cnt = 0;
    int mis_cnt = 0;

    // per-edge stimulus for one run; edge 0 is the edge that samples start
    bit tk[MAXE];
    bit er[MAXE];
    bit ab[MAXE];
    bit st[MAXE];

    int     m_end;
    bit     m_abort;
    longint m_errs;
    longint prev_bits[2];
    longint prev_errs[2];

    typedef struct {
        bit     sel;
        int     win;
        int     period;
        bit     err_align;
        int     err_lo;
        int     err_hi;
        int     abort_at;
        bit     ab_done;
        bit     exp_done;
        longint exp_bits;
        longint exp_errs;
    } vec_t;

    vec_t vt[7];

    task automatic chk(input string nm, input longint act, input longint exp);
        vec_cnt++;
        if (act != exp) begin
            mis_cnt++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic drv(input bit s, input bit st_v, input bit ab_v, input bit tk_v,
                       input bit er_v, input int w);
        use_b   = s;
        start_a = !s && st_v;
        abort_a = !s && ab_v;
        tick_a  = !s && tk_v;
        err_a   = !s && er_v;
        win_a   = s ? 32'd0 : w;
        start_b = s && st_v;
        abort_b = s && ab_v;
        tick_b  = s && tk_v;
        err_b   = s && er_v;
        win_b   = s ? w[3:0] : 4'd0;
    endtask

    task automatic tick_edge();
        @(posedge clk);
        #1;
    endtask

    // The run ends at the first abort (edges 1..) or at the tick that completes ALEN+win ticks
    // counted from edge 2; errors count only on ticks past the first ALEN.
    task automatic compute_model(input int win, input longint satmax);
        longint cum = 0;
        longint esum = 0;
        m_end   = -1;
        m_abort = 1'b0;
        for (int e = 1; e < MAXE; e++) begin
            if (ab[e]) begin
                m_end   = e;
                m_abort = 1'b1;
                break;
            end
            if (e >= 2 && tk[e]) begin
                cum++;
                if (cum > ALEN && er[e]) esum++;
                if (cum == ALEN + win) begin
                    m_end = e;
                    break;
                end
            end
        end
        m_errs = (esum > satmax) ? satmax : esum;
    endtask

    task automatic clear_stim();
        for (int e = 0; e < MAXE; e++) begin
            tk[e] = 1'b0; er[e] = 1'b0; ab[e] = 1'b0; st[e] = 1'b0;
        end
    endtask

    task automatic build_directed(input vec_t v);
        int n = 0;
        clear_stim();
        for (int e = 1; e < MAXE; e++) begin
            tk[e] = (e % v.period == 0);
            if (e >= 2 && tk[e]) begin
                n++;
                if (n <= ALEN) begin
                    er[e] = v.err_align;
                end else begin
                    er[e] = (n - ALEN >= v.err_lo) && (n - ALEN <= v.err_hi);
                    if (n - ALEN == v.abort_at) ab[e] = 1'b1;
                end
            end
        end
    endtask

    task automatic build_random(input int p_tick, input int p_err);
        clear_stim();
        for (int e = 1; e < MAXE; e++) begin
            tk[e] = (e >= 700) ? 1'b1 : ($urandom_range(0, 99) < p_tick);
            er[e] = ($urandom_range(0, 99) < p_err);
            ab[e] = ($urandom_range(0, 299) == 0);
            st[e] = ($urandom_range(0, 3) == 0);
        end
    endtask

    task automatic apply_run(input bit s, input int win, input bit exp_done,
                             input longint eb, input longint ee, input bit ab_done);
        if (m_end < 1) begin
            chk("model_end_found", 0, 1);
            return;
        end
        drv(s, 1'b1, 1'b0, 1'b0, 1'b0, win);
        @(negedge clk);
        chk("idle_busy_at_start", c_busy, 0);
        tick_edge();
        for (int e = 1; e <= m_end; e++) begin
            drv(s, st[e], ab[e], tk[e], er[e], win);
            @(negedge clk);
            chk("run_busy", c_busy, 1);
            chk("run_ber_clr", c_clr, (e == 1));
            chk("run_ber_enable", c_en, (e >= 2) && tk[e]);
            chk("run_no_done", c_done, 0);
            chk("run_no_aborted", c_abd, 0);
            tick_edge();
        end
        drv(s, 1'b0, ab_done, 1'b0, 1'b0, win);
        @(negedge clk);
        chk("end_done", c_done, exp_done);
        chk("end_aborted", c_abd, !exp_done);
        chk("end_busy", c_busy, exp_done);
        chk("end_ber_enable", c_en, 0);
        chk("res_bits", c_bits, eb);
        chk("res_errs", c_errs, ee);
        tick_edge();
        drv(s, 1'b0, 1'b0, 1'b0, 1'b0, win);
        @(negedge clk);
        chk("after_busy", c_busy, 0);
        chk("after_done", c_done, 0);
        chk("after_aborted", c_abd, 0);
        chk("after_res_bits", c_bits, eb);
        chk("after_res_errs", c_errs, ee);
        tick_edge();
        prev_bits[s] = eb;
        prev_errs[s] = ee;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int win;
        bit s;

        vt[0] = '{1'b0, 100, 1, 1'b0, 1, 0, 0, 1'b0, 1'b1, 100, 0};
        vt[1] = '{1'b0, 100, 1, 1'b0, 1, 0, 6, 1'b0, 1'b0, 100, 0};
        vt[2] = '{1'b0, 10,  1, 1'b1, 4, 6, 0, 1'b0, 1'b1, 10,  3};
        vt[3] = '{1'b1, 15,  3, 1'b1, 1, 15, 0, 1'b0, 1'b1, 15, 15};
        vt[4] = '{1'b0, 1,   2, 1'b1, 1, 1, 1, 1'b0, 1'b0, 10,  3};
        vt[5] = '{1'b1, 1,   1, 1'b1, 1, 1, 0, 1'b0, 1'b1, 1,   1};
        vt[6] = '{1'b0, 3,   1, 1'b0, 1, 0, 0, 1'b1, 1'b1, 3,   0};

        rst_n = 1'b0;
        drv(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0);
        #3;
        chk("rst_busy", c_busy, 0);
        chk("rst_ber_enable", c_en, 0);
        chk("rst_ber_clr", c_clr, 0);
        chk("rst_done", c_done, 0);
        chk("rst_aborted", c_abd, 0);
        chk("rst_cfg_err", c_cfg, 0);
        chk("rst_res_bits", c_bits, 0);
        chk("rst_res_errs", c_errs, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick_edge();

        // zero window is rejected
        drv(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 0);
        tick_edge();
        drv(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0);
        @(negedge clk);
        chk("cfg_err_pulse", c_cfg, 1);
        chk("cfg_err_busy", c_busy, 0);
        tick_edge();
        @(negedge clk);
        chk("cfg_err_clears", c_cfg, 0);
        chk("cfg_err_still_idle", c_busy, 0);

        // start together with abort in IDLE is dropped
        tick_edge();
        drv(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 5);
        tick_edge();
        drv(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5);
        @(negedge clk);
        chk("contention_busy", c_busy, 0);
        chk("contention_cfg_err", c_cfg, 0);
        chk("contention_aborted", c_abd, 0);
        chk("contention_ber_clr", c_clr, 0);
        tick_edge();

        // nominal latency: done in cycle 1+1+57+100 counted from the start cycle
        drv(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 100);
        tick_edge();
        cyc = 1;
        drv(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 100);
        while (cyc < 400) begin
            @(negedge clk);
            if (c_done) break;
            tick_edge();
            cyc++;
        end
        chk("nominal_latency", cyc, 159);
        chk("nominal_bits", c_bits, 100);
        tick_edge();
        drv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        @(negedge clk);
        chk("nominal_busy_after_done", c_busy, 0);
        tick_edge();

        prev_bits[0] = 100; prev_errs[0] = 0;
        prev_bits[1] = 0;   prev_errs[1] = 0;

        for (int i = 0; i < 7; i++) begin
            build_directed(vt[i]);
            compute_model(vt[i].win, vt[i].sel ? 64'd15 : 64'hFFFF_FFFF);
            apply_run(vt[i].sel, vt[i].win, vt[i].exp_done, vt[i].exp_bits,
                      vt[i].exp_errs, vt[i].ab_done);
        end

        // reset during ALIGN
        drv(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 50);
        tick_edge();
        for (int i = 0; i < 20; i++) begin
            drv(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 50);
            tick_edge();
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", c_busy, 0);
        chk("midrst_ber_enable", c_en, 0);
        chk("midrst_res_bits", c_bits, 0);
        chk("midrst_res_errs", c_errs, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("midrst_no_done", c_done, 0);
            chk("midrst_no_aborted", c_abd, 0);
        end
        rst_n = 1'b1;
        tick_edge();
        @(negedge clk);
        chk("postrst_no_done", c_done, 0);
        chk("postrst_no_aborted", c_abd, 0);
        tick_edge();
        prev_bits[0] = 0; prev_errs[0] = 0;
        prev_bits[1] = 0; prev_errs[1] = 0;
        vt[0].win = 5;
        build_directed(vt[0]);
        compute_model(5, 64'hFFFF_FFFF);
        apply_run(1'b0, 5, 1'b1, 5, 0, 1'b0);

        for (int r = 0; r < 30; r++) begin
            s   = ($urandom_range(0, 1) == 1);
            win = s ? int'($urandom_range(1, 15)) : int'($urandom_range(1, 20));
            build_random(int'($urandom_range(25, 100)), int'($urandom_range(0, 100)));
            compute_model(win, s ? 64'd15 : 64'hFFFF_FFFF);
            if (m_abort)
                apply_run(s, win, 1'b0, prev_bits[s], prev_errs[s], 1'b0);
            else
                apply_run(s, win, 1'b1, win, m_errs, ($urandom_range(0, 1) == 1));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, mis_cnt);
        $finish;
    end

endmodule

// File: doc/ber_ctrl.md
BER_CTRL -- requirements
Module: ber_ctrl

Interface
REQ-001 The block SHALL have parameter SEQ_LEN, default 511, meaning the PRBS length of the attached BER checker.
REQ-002 The block SHALL have parameter REG_LEN, default 32, meaning the width of the window length and result counters.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port start, input, 1 bit: request one measurement; sampled in IDLE only.
REQ-006 The block SHALL have port abort, input, 1 bit: cancel the run in progress.
REQ-007 The block SHALL have port win_len, input, REG_LEN bits: measurement window in bits; latched when start is accepted.
REQ-008 The block SHALL have port sample_tick, input, 1 bit: symbol strobe, one per received bit.
REQ-009 The block SHALL have port err_in, input, 1 bit: per-bit error from the checker; valid only with sample_tick.
REQ-010 The block SHALL have port ber_enable, output, 1 bit: enable to the checker.
REQ-011 The block SHALL have port ber_clr, output, 1 bit: synchronous clear to the checker.
REQ-012 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-013 The block SHALL have port done, output, 1 bit: one-cycle pulse when results are updated.
REQ-014 The block SHALL have port aborted, output, 1 bit: one-cycle pulse when a run is cancelled.
REQ-015 The block SHALL have port cfg_err, output, 1 bit: one-cycle pulse when start is rejected because win_len == 0.
REQ-016 The block SHALL have port res_bits, output, REG_LEN bits: bits counted in the last completed window.
REQ-017 The block SHALL have port res_errs, output, REG_LEN bits: errors counted in the last completed window.

Function
REQ-018 The FSM SHALL have the states IDLE, CLEAR, ALIGN, MEASURE and DONE.
REQ-019 In IDLE, start=1 with win_len!=0 SHALL latch win_len and move to CLEAR on the next edge; busy SHALL rise 1 cycle after start.
REQ-020 In IDLE, start=1 with win_len==0 SHALL pulse cfg_err for one cycle, and the FSM SHALL stay in IDLE.
REQ-021 CLEAR SHALL last exactly 1 cycle with ber_clr=1, then move to ALIGN; ber_clr SHALL be 0 in all other states.
REQ-022 ALIGN SHALL count sample_ticks and move to MEASURE on the tick that brings the count to ALIGN_LEN = SEQ_LEN*(SEQ_LEN+1)+1.
REQ-023 ber_enable SHALL equal sample_tick AND (state is ALIGN or MEASURE), combinationally, with zero latency.
REQ-024 In MEASURE, every sample_tick SHALL increment the bit counter and add err_in to the error counter.
REQ-025 The error counter SHALL saturate at all-ones; the bit counter cannot exceed win_len.
REQ-026 In MEASURE, the tick that brings the bit count to the latched win_len SHALL be counted, and the FSM SHALL then move to DONE.
REQ-027 On entry to DONE, res_bits and res_errs SHALL be loaded from the counters and done SHALL pulse for 1 cycle; DONE SHALL then return to IDLE.
REQ-028 res_bits and res_errs SHALL hold their values until the next DONE.
REQ-029 abort=1 in CLEAR, ALIGN or MEASURE SHALL move the FSM to IDLE on the next edge and pulse aborted, leaving res_* unchanged.
REQ-030 ber_enable SHALL be 0 from the cycle after abort is sampled.
REQ-031 abort in DONE SHALL be ignored (results already committed).
REQ-032 abort with start in IDLE: abort SHALL win and the start SHALL be dropped.
REQ-033 start outside IDLE SHALL be ignored.
REQ-034 sample_tick=0 SHALL freeze all counters, while still allowing abort.
REQ-035 The internal align and bit counters SHALL be cleared on entry to CLEAR.

Reset
REQ-036 rst=0 SHALL asynchronously force: state IDLE; busy, done, aborted, cfg_err, ber_clr = 0; ber_enable = 0; res_bits = 0, res_errs = 0; all counters and the latched window = 0.
REQ-037 Reset asserted mid-run SHALL discard the run without a done or aborted pulse.

Structure
REQ-038 A shared package SHALL hold the FSM state encoding, REG_LEN default, SEQ_LEN default, and the ALIGN_LEN function/constant with its width $clog2(ALIGN_LEN+1).
REQ-039 The saturating accumulator SHALL be a sub-module named sat_counter, parameterised by width, with clr, inc_en and inc inputs.
REQ-040 No other hierarchy SHALL be used.

Verification (SEQ_LEN=7, so ALIGN_LEN=57; sample_tick=1 every cycle unless stated)
REQ-041 Nominal run: win_len=100, err_in=0 throughout -> done at 1+1+57+100 cycles after start, res_bits=100, res_errs=0, busy low the cycle after done.
REQ-042 Errors: win_len=10, err_in=1 on 3 MEASURE ticks -> res_errs=3, res_bits=10; err_in=1 during ALIGN not counted.
REQ-043 Abort: abort in MEASURE after 5 ticks -> aborted pulse, idle next cycle, res_* keep previous values (100/0), no done pulse.
REQ-044 Config and contention: start with win_len=0 -> cfg_err pulse, busy stays 0; start and abort together in IDLE -> no run.
REQ-045 Saturation and stalls: REG_LEN=4, win_len=15, err_in=1 every tick, sample_tick every 3rd cycle -> res_errs=15, res_bits=15, and ber_enable pulses match sample_tick one-for-one.
REQ-046 Reset mid-run: rst low during ALIGN -> all outputs 0 immediately, no done or aborted pulse; a subsequent start runs nominally.
